// File: rtl/conv_1st_ofmap_collect.sv
// First-layer conv result collector: bias, ReLU, requantize,
// buffer two tiles and serialize lanes with feature-map addresses.
module conv_1st_ofmap_collect #(
  parameter int LANES  = 6,
  parameter int ACC_W  = 20,
  parameter int BIAS_W = 16,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 8,
  parameter int CH     = 32,
  parameter int TILES  = 2,
  parameter int PASSES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_i,
  input  logic [4:0]             ch_i,
  input  logic [LANES*ACC_W-1:0] psum_i,
  input  logic [BIAS_W-1:0]      bias_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic [15:0]            out_addr,
  output logic [4:0]             out_ch,
  output logic                   seq_err,
  output logic                   ovf_err,
  output logic                   layer_done
);

  localparam int SW = ACC_W + 1;
  localparam int TW = (TILES > 1) ? $clog2(TILES) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int VW = LANES * OUT_W;

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t state, state_n;

  logic [TW-1:0] tile;
  logic [4:0]    ch;
  logic [PW-1:0] pass;
  logic [LW-1:0] lane;

  logic [VW-1:0] f_data [2];
  logic [TW-1:0] f_tile [2];
  logic [4:0]    f_ch   [2];
  logic [PW-1:0] f_pass [2];
  logic          f_last [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;

  logic [VW-1:0] proc;
  logic          pop;
  logic          accept;
  logic          last_tag;

  function automatic logic [OUT_W-1:0] requant(
    input logic [ACC_W-1:0]  p,
    input logic [BIAS_W-1:0] b
  );
    logic [SW-1:0] s;
    logic [SW:0]   r;
    s = {{(SW-ACC_W){p[ACC_W-1]}}, p}
      + {{(SW-BIAS_W){b[BIAS_W-1]}}, b};
    r = {1'b0, s} + (SW+1)'(1 << (SHIFT-1));
    r = r >> SHIFT;
    if (s[SW-1])
      return '0;
    else if (|r[SW:OUT_W])
      return '1;
    else
      return r[OUT_W-1:0];
  endfunction

  assign pop = (state == S_EMIT) && out_ready
            && (lane == LW'(LANES-1));
  assign accept = valid_i && ((count != 2'd2) || pop);
  assign last_tag = (tile == TW'(TILES-1))
                 && (ch == 5'(CH-1))
                 && (pass == PW'(PASSES-1));

  // Per-lane bias, ReLU and rounded requantization of the incoming pulse
  always_comb begin
    proc = '0;
    for (int l = 0; l < LANES; l++)
      proc[l*OUT_W +: OUT_W] = requant(psum_i[l*ACC_W +: ACC_W], bias_i);
  end

  // Two-entry result buffer; a full buffer frees a slot on a same-cycle pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        f_data[i] <= '0;
        f_tile[i] <= '0;
        f_ch[i]   <= '0;
        f_pass[i] <= '0;
        f_last[i] <= 1'b0;
      end
    end else begin
      if (accept) begin
        f_data[wr_ptr] <= proc;
        f_tile[wr_ptr] <= tile;
        f_ch[wr_ptr]   <= ch;
        f_pass[wr_ptr] <= pass;
        f_last[wr_ptr] <= last_tag;
        wr_ptr <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      if (accept && !pop)
        count <= count + 2'd1;
      else if (!accept && pop)
        count <= count - 2'd1;
    end
  end

  // Expected tile/channel/pass position, advanced per accepted pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile <= '0;
      ch   <= '0;
      pass <= '0;
    end else if (accept) begin
      if (tile == TW'(TILES-1)) begin
        tile <= '0;
        if (ch == 5'(CH-1)) begin
          ch <= '0;
          if (pass == PW'(PASSES-1))
            pass <= '0;
          else
            pass <= pass + PW'(1);
        end else begin
          ch <= ch + 5'd1;
        end
      end else begin
        tile <= tile + TW'(1);
      end
    end
  end

  // Lane pointer within the head entry, advanced per handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lane <= '0;
    else if (pop)
      lane <= '0;
    else if (out_valid && out_ready)
      lane <= lane + LW'(1);
  end

  // Sticky sequence and overflow flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_err <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      if (accept && (ch_i != ch))
        seq_err <= 1'b1;
      if (valid_i && !accept)
        ovf_err <= 1'b1;
    end
  end

  // Layer completion pulse once the final tagged entry drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      layer_done <= 1'b0;
    else
      layer_done <= pop && f_last[rd_ptr];
  end

  // Serializer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // Serializer next state: wake on capture, sleep when last entry pops
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (accept)
          state_n = S_EMIT;
      S_EMIT:
        if (pop && (count == 2'd1) && !accept)
          state_n = S_IDLE;
    endcase
  end

  // Serializer outputs: current lane of the head entry and its address
  always_comb begin
    out_valid = (state == S_EMIT);
    out_data  = f_data[rd_ptr][lane*OUT_W +: OUT_W];
    out_ch    = f_ch[rd_ptr];
    out_addr  = 16'(f_ch[rd_ptr]) * 16'(PASSES*TILES*LANES)
              + (16'(f_pass[rd_ptr]) * 16'(TILES)
              + 16'(f_tile[rd_ptr])) * 16'(LANES)
              + 16'(lane);
  end

endmodule

// File: tb/tb_conv_1st_ofmap_collect.sv
// Scoreboard bench for conv_1st_ofmap_collect.
// Beats are predicted at drive time and matched on output.
module tb_conv_1st_ofmap_collect;

  localparam int LANES  = 6;
  localparam int ACC_W  = 20;
  localparam int BIAS_W = 16;
  localparam int OUT_W  = 8;
  localparam int SHIFT  = 8;
  localparam int CH     = 32;
  localparam int TILES  = 2;
  localparam int PASSES = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   valid_i = 1'b0;
  logic [4:0]             ch_i = '0;
  logic [LANES*ACC_W-1:0] psum_i = '0;
  logic [BIAS_W-1:0]      bias_i = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [OUT_W-1:0]       out_data;
  logic [15:0]            out_addr;
  logic [4:0]             out_ch;
  logic                   seq_err;
  logic                   ovf_err;
  logic                   layer_done;

  conv_1st_ofmap_collect #(
    .LANES(LANES), .ACC_W(ACC_W), .BIAS_W(BIAS_W),
    .OUT_W(OUT_W), .SHIFT(SHIFT), .CH(CH),
    .TILES(TILES), .PASSES(PASSES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i),
    .ch_i(ch_i), .psum_i(psum_i), .bias_i(bias_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr),
    .out_ch(out_ch), .seq_err(seq_err),
    .ovf_err(ovf_err), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int a;
    int c;
  } beat_t;

  beat_t sb[$];
  beat_t e;
  int n_chk = 0;
  int n_pass = 0;
  int mt = 0;
  int mc = 0;
  int mp = 0;
  int pv[LANES];
  int n_beats = 0;
  int n_done = 0;
  int b0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
  endtask

  function automatic int rq(input int p, input int b);
    int s;
    int r;
    s = p + b;
    if (s < 0)
      return 0;
    r = (s + (1 << (SHIFT-1))) >>> SHIFT;
    if (r > (1 << OUT_W) - 1)
      r = (1 << OUT_W) - 1;
    return r;
  endfunction

  task automatic send(input int chv, input int b, input bit acc);
    beat_t x;
    @(posedge clk);
    #1;
    valid_i = 1'b1;
    ch_i    = 5'(chv);
    bias_i  = 16'(b);
    for (int l = 0; l < LANES; l++)
      psum_i[l*ACC_W +: ACC_W] = 20'(pv[l]);
    if (acc) begin
      for (int l = 0; l < LANES; l++) begin
        x.d = rq(pv[l], b);
        x.a = (mc*PASSES*TILES*LANES + (mp*TILES + mt)*LANES + l) % 65536;
        x.c = mc;
        sb.push_back(x);
      end
      mt++;
      if (mt == TILES) begin
        mt = 0;
        mc++;
        if (mc == CH) begin
          mc = 0;
          mp = (mp + 1) % PASSES;
        end
      end
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !out_valid)
        break;
      @(negedge clk);
      #1;
    end
    check(tag, sb.size(), 0);
  endtask

  task automatic wait_left(input int n);
    for (int i = 0; i < 50; i++) begin
      if (sb.size() <= n)
        break;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    mt = 0;
    mc = 0;
    mp = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill(input int v);
    for (int l = 0; l < LANES; l++)
      pv[l] = v;
  endtask

  // Output monitor: every visible beat is compared with the queue head
  always @(negedge clk) begin
    if (rst_n) begin
      if (layer_done)
        n_done++;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          e = sb[0];
          check("data", int'(out_data), e.d);
          check("addr", int'(out_addr), e.a);
          check("ch", int'(out_ch), e.c);
          if (out_ready) begin
            void'(sb.pop_front());
            n_beats++;
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_seq", int'(seq_err), 0);
    check("rst_ovf", int'(ovf_err), 0);
    check("rst_done", int'(layer_done), 0);
    check("rst_addr", int'(out_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single pulse, latency and lane mapping
    out_ready = 1'b1;
    pv[0] = 256; pv[1] = 511; pv[2] = -5;
    pv[3] = 0;   pv[4] = 65535; pv[5] = 384;
    send(0, 0, 1'b1);
    @(negedge clk);
    check("lat_t", int'(out_valid), 0);
    idle();
    @(negedge clk);
    check("lat_t1", int'(out_valid), 1);
    check("lat_addr0", int'(out_addr), 0);
    check("lat_data0", int'(out_data), 1);
    drain("drain_single");

    // bias path
    fill(100);
    send(mc, -300, 1'b1);
    idle();
    drain("drain_bias_neg");
    send(mc, 412, 1'b1);
    idle();
    drain("drain_bias_pos");

    // backpressure mid-entry
    for (int l = 0; l < LANES; l++)
      pv[l] = 300 * l + 77;
    send(mc, 5, 1'b1);
    idle();
    wait_left(4);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("drain_bp");

    // overflow: third back-to-back pulse must be dropped
    out_ready = 1'b0;
    fill(1000);
    send(mc, 0, 1'b1);
    fill(2000);
    send(mc, 0, 1'b1);
    fill(3000);
    send(mc, 0, 1'b0);
    idle();
    @(negedge clk);
    check("ovf_set", int'(ovf_err), 1);
    check("ovf_seq", int'(seq_err), 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("drain_ovf");
    fill(4000);
    send(mc, 0, 1'b1);
    idle();
    drain("drain_post_ovf");

    // async reset in the middle of an entry
    fill(700);
    send(mc, 0, 1'b1);
    idle();
    wait_left(3);
    @(posedge clk);
    #2;
    check("pre_rst_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", int'(out_valid), 0);
    check("rst_async_ovf", int'(ovf_err), 0);
    sb.delete();
    mt = 0;
    mc = 0;
    mp = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fill(900);
    send(0, 0, 1'b1);
    idle();
    @(negedge clk);
    check("post_rst_addr", int'(out_addr), 0);
    drain("drain_post_rst");

    // full layer
    do_reset();
    n_done = 0;
    b0 = n_beats;
    for (int k = 0; k < CH*TILES*PASSES; k++) begin
      for (int l = 0; l < LANES; l++)
        pv[l] = int'($urandom_range(0, 140000)) - 20000;
      send((k / 2) % 32, int'($urandom_range(0, 800)) - 400, 1'b1);
      idle();
      repeat (7) @(posedge clk);
    end
    drain("drain_layer");
    repeat (2) @(negedge clk);
    check("layer_beats", n_beats - b0, CH*TILES*PASSES*LANES);
    check("layer_seq", int'(seq_err), 0);
    check("layer_ovf", int'(ovf_err), 0);
    check("layer_done_cnt", n_done, 1);

    // wrong channel tag after the layer wrapped
    fill(500);
    send((mc + 3) % 32, 0, 1'b1);
    idle();
    @(negedge clk);
    check("seq_set", int'(seq_err), 1);
    drain("drain_seq");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
